// File: rtl/day_name_scroller.sv
// day_name_scroller: steps a day register and scans up to three letters of its name onto a 7-segment bus
module day_name_scroller #(
    parameter int DWELL      = 50_000_000,
    parameter int SCAN_DIV   = 50_000,
    parameter int NUM_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  load,
    input  logic [2:0]            load_day,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [2:0]            day,
    output logic                  day_tick
);
    localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [3:0] {
        L_A, L_D, L_E, L_F, L_H, L_I, L_M,
        L_N, L_O, L_R, L_S, L_T, L_U, L_W, L_BLANK
    } letter_t;

    logic [DW-1:0]         dwell_cnt, dwell_n;
    logic [SW-1:0]         scan_cnt, scan_cnt_n;
    logic [IW-1:0]         scan_idx, scan_idx_n;
    logic [2:0]            day_n, step_day, ld;
    logic                  term, adv, scan_wrap;
    logic [6:0]            seg_n;
    logic [NUM_DIGITS-1:0] sel_n;
    logic                  tick_n;

    function automatic letter_t letter_at(input logic [2:0] d, input logic [1:0] i);
        letter_t l0, l1, l2;
        case (d)
            3'd0:    begin l0 = L_M; l1 = L_O; l2 = L_N; end
            3'd1:    begin l0 = L_T; l1 = L_U; l2 = L_E; end
            3'd2:    begin l0 = L_W; l1 = L_E; l2 = L_D; end
            3'd3:    begin l0 = L_T; l1 = L_H; l2 = L_U; end
            3'd4:    begin l0 = L_F; l1 = L_R; l2 = L_I; end
            3'd5:    begin l0 = L_S; l1 = L_A; l2 = L_T; end
            3'd6:    begin l0 = L_S; l1 = L_U; l2 = L_N; end
            default: begin l0 = L_BLANK; l1 = L_BLANK; l2 = L_BLANK; end
        endcase
        return i == 2'd0 ? l0 : i == 2'd1 ? l1 : l2;
    endfunction

    function automatic logic [6:0] glyph(input letter_t l);
        case (l)
            L_A:     return 7'b1110111;
            L_D:     return 7'b0111101;
            L_E:     return 7'b1001111;
            L_F:     return 7'b1000111;
            L_H:     return 7'b0110111;
            L_I:     return 7'b0110000;
            L_M:     return 7'b1110110;
            L_N:     return 7'b0010101;
            L_O:     return 7'b1111110;
            L_R:     return 7'b0000101;
            L_S:     return 7'b1011011;
            L_T:     return 7'b0001111;
            L_U:     return 7'b0111110;
            L_W:     return 7'b0111111;
            default: return 7'b0000000;
        endcase
    endfunction

    // next day, dwell and scan position; load beats the terminal-count advance
    always_comb begin
        ld         = load_day == 3'd7 ? 3'd0 : load_day;
        term       = en && dwell_cnt == DW'(DWELL - 1);
        adv        = term && !load;
        step_day   = dir ? (day == 3'd0 ? 3'd6 : day - 3'd1) : (day == 3'd6 ? 3'd0 : day + 3'd1);
        day_n      = load ? ld : adv ? step_day : day;
        dwell_n    = load || term ? '0 : en ? dwell_cnt + DW'(1) : dwell_cnt;
        scan_wrap  = scan_cnt == SW'(SCAN_DIV - 1);
        scan_cnt_n = scan_wrap ? '0 : scan_cnt + SW'(1);
        scan_idx_n = !scan_wrap ? scan_idx : scan_idx == IW'(NUM_DIGITS - 1) ? '0 : scan_idx + IW'(1);
    end

    // output values derived from next state so every output lands on the same edge as its state
    always_comb begin
        seg_n  = glyph(letter_at(day_n, 2'(scan_idx_n)));
        sel_n  = NUM_DIGITS'(1) << scan_idx_n;
        tick_n = adv;
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            day       <= 3'd0;
            dwell_cnt <= '0;
            scan_cnt  <= '0;
            scan_idx  <= '0;
            digit_sel <= NUM_DIGITS'(1);
            seg       <= glyph(L_M);
            day_tick  <= 1'b0;
        end else begin
            day       <= day_n;
            dwell_cnt <= dwell_n;
            scan_cnt  <= scan_cnt_n;
            scan_idx  <= scan_idx_n;
            digit_sel <= sel_n;
            seg       <= seg_n;
            day_tick  <= tick_n;
        end
    end
endmodule

// File: tb/tb_day_name_scroller.sv
// tb_day_name_scroller: directed checks of day stepping, load, hold, reset and letter scanning
module tb_day_name_scroller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_day = 3'd0;
    logic [6:0] seg;
    logic [2:0] digit_sel;
    logic [2:0] day;
    logic       day_tick;
    int         passed = 0;
    int         total = 0;

    localparam logic [6:0] G_M = 7'b1110110;
    localparam logic [6:0] G_O = 7'b1111110;
    localparam logic [6:0] G_N = 7'b0010101;
    localparam logic [6:0] G_S = 7'b1011011;
    localparam logic [6:0] G_U = 7'b0111110;
    localparam logic [6:0] G_I = 7'b0110000;
    localparam logic [2:0] SEL_T [7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    localparam logic [6:0] SEG_T [7] = '{G_M, G_M, G_O, G_O, G_N, G_N, G_M};
    localparam logic       EN_T  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    day_name_scroller #(.DWELL(4), .SCAN_DIV(2), .NUM_DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_day(load_day),
        .seg(seg), .digit_sel(digit_sel), .day(day), .day_tick(day_tick)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_day = 3'd0;
        step;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (day !== 3'd0) $display("FAIL reset_day got %0d exp 0", day); else passed++;
        total++; if (digit_sel !== 3'b001) $display("FAIL reset_sel got %b exp 001", digit_sel); else passed++;
        total++; if (seg !== G_M) $display("FAIL reset_seg got %b exp %b", seg, G_M); else passed++;
        total++; if (day_tick !== 1'b0) $display("FAIL reset_tick got %b exp 0", day_tick); else passed++;
    endtask

    task automatic test_forward;
        logic [2:0] exp_day;
        logic       exp_tick;
        do_reset;
        en = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            step;
            exp_day  = 3'((c / 4) % 7);
            exp_tick = (c % 4) == 0;
            total++; if (day !== exp_day) $display("FAIL fwd_day c=%0d got %0d exp %0d", c, day, exp_day); else passed++;
            total++; if (day_tick !== exp_tick) $display("FAIL fwd_tick c=%0d got %b exp %b", c, day_tick, exp_tick); else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_scan;
        do_reset;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) step;
            total++; if (digit_sel !== SEL_T[c]) $display("FAIL scan_sel c=%0d got %b exp %b", c, digit_sel, SEL_T[c]); else passed++;
            total++; if (seg !== SEG_T[c]) $display("FAIL scan_seg c=%0d got %b exp %b", c, seg, SEG_T[c]); else passed++;
        end
    endtask

    task automatic test_backward;
        do_reset;
        en = 1'b1; dir = 1'b1;
        repeat (4) step;
        total++; if (day !== 3'd6) $display("FAIL back_day got %0d exp 6", day); else passed++;
        total++; if (day_tick !== 1'b1) $display("FAIL back_tick got %b exp 1", day_tick); else passed++;
        total++; if (seg !== G_N) $display("FAIL back_seg_n1 got %b exp %b", seg, G_N); else passed++;
        en = 1'b0;
        repeat (2) step;
        total++; if (seg !== G_S) $display("FAIL back_seg_s got %b exp %b", seg, G_S); else passed++;
        repeat (2) step;
        total++; if (seg !== G_U) $display("FAIL back_seg_u got %b exp %b", seg, G_U); else passed++;
        repeat (2) step;
        total++; if (seg !== G_N) $display("FAIL back_seg_n2 got %b exp %b", seg, G_N); else passed++;
        total++; if (day_tick !== 1'b0) $display("FAIL back_hold_tick got %b exp 0", day_tick); else passed++;
        en = 1'b1;
        repeat (3) step;
        total++; if (day_tick !== 1'b0) $display("FAIL back_early_tick got %b exp 0", day_tick); else passed++;
        step;
        total++; if (day !== 3'd5) $display("FAIL back_day2 got %0d exp 5", day); else passed++;
        total++; if (day_tick !== 1'b1) $display("FAIL back_tick2 got %b exp 1", day_tick); else passed++;
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_en_hold;
        do_reset;
        for (int i = 0; i < 7; i++) begin
            en = EN_T[i];
            step;
            total++; if (day_tick !== (i == 6)) $display("FAIL hold_tick clk=%0d got %b exp %b", i + 1, day_tick, i == 6); else passed++;
            total++; if (day !== (i == 6 ? 3'd1 : 3'd0)) $display("FAIL hold_day clk=%0d got %0d", i + 1, day); else passed++;
            if (i == 3) begin
                total++; if (digit_sel !== 3'b100) $display("FAIL hold_scan got %b exp 100", digit_sel); else passed++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load;
        do_reset;
        en = 1'b1;
        repeat (3) step;
        load = 1'b1; load_day = 3'd4;
        step;
        load = 1'b0;
        total++; if (day !== 3'd4) $display("FAIL load4_day got %0d exp 4", day); else passed++;
        total++; if (day_tick !== 1'b0) $display("FAIL load4_tick got %b exp 0", day_tick); else passed++;
        total++; if (seg !== G_I) $display("FAIL load4_seg got %b exp %b", seg, G_I); else passed++;
        for (int i = 0; i < 3; i++) begin
            step;
            total++; if (day_tick !== 1'b0) $display("FAIL load4_wait_tick i=%0d got %b exp 0", i, day_tick); else passed++;
        end
        step;
        total++; if (day_tick !== 1'b1) $display("FAIL load4_next_tick got %b exp 1", day_tick); else passed++;
        total++; if (day !== 3'd5) $display("FAIL load4_next_day got %0d exp 5", day); else passed++;
        repeat (3) step;
        load = 1'b1; load_day = 3'd7;
        step;
        load = 1'b0;
        total++; if (day !== 3'd0) $display("FAIL load7_day got %0d exp 0", day); else passed++;
        total++; if (day_tick !== 1'b0) $display("FAIL load7_tick got %b exp 0", day_tick); else passed++;
        total++; if (seg !== G_M) $display("FAIL load7_seg got %b exp %b", seg, G_M); else passed++;
        for (int i = 0; i < 3; i++) begin
            step;
            total++; if (day_tick !== 1'b0) $display("FAIL load7_wait_tick i=%0d got %b exp 0", i, day_tick); else passed++;
        end
        step;
        total++; if (day_tick !== 1'b1) $display("FAIL load7_next_tick got %b exp 1", day_tick); else passed++;
        total++; if (day !== 3'd1) $display("FAIL load7_next_day got %0d exp 1", day); else passed++;
        en = 1'b0;
    endtask

    task automatic test_dir_change;
        do_reset;
        en = 1'b1;
        repeat (2) step;
        dir = 1'b1;
        step;
        total++; if (day_tick !== 1'b0) $display("FAIL dirchg_tick3 got %b exp 0", day_tick); else passed++;
        step;
        total++; if (day !== 3'd6) $display("FAIL dirchg_day got %0d exp 6", day); else passed++;
        total++; if (day_tick !== 1'b1) $display("FAIL dirchg_tick got %b exp 1", day_tick); else passed++;
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset;
        en = 1'b1;
        repeat (15) step;
        total++; if (day !== 3'd3) $display("FAIL mid_pre_day got %0d exp 3", day); else passed++;
        rst_n = 1'b0; load = 1'b1; load_day = 3'd5;
        step;
        total++; if (day !== 3'd0) $display("FAIL mid_day got %0d exp 0", day); else passed++;
        total++; if (digit_sel !== 3'b001) $display("FAIL mid_sel got %b exp 001", digit_sel); else passed++;
        total++; if (seg !== G_M) $display("FAIL mid_seg got %b exp %b", seg, G_M); else passed++;
        total++; if (day_tick !== 1'b0) $display("FAIL mid_tick got %b exp 0", day_tick); else passed++;
        rst_n = 1'b1; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset;
        test_forward;
        test_scan;
        test_backward;
        test_en_hold;
        test_load;
        test_dir_change;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/day_name_scroller.md
# day_name_scroller

Parametrised seven-segment day-of-week display driver for the board's display path. It steps a day register through MON to SUN with a programmable dwell time, and can step forward or backward or load a day directly. It time-multiplexes up to three letters of the day name onto a shared seg bus with one-hot digit selects. It supersedes the single-letter fixed-rate day display blocks.

## Interface
- DWELL, default 50_000_000: enabled clock cycles per day; legal range ≥1.
- SCAN_DIV, default 50_000: clock cycles each digit stays selected; legal range ≥1.
- NUM_DIGITS, default 3: letters shown, taken from the start of the name; legal range 1..3.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  dwell counting enable; scanning runs regardless.
- dir  in  1  0 = forward (MON→TUE…), 1 = backward.
- load  in  1  one-cycle request to load load_day.
- load_day  in  3  0=MON … 6=SUN; 7 is treated as 0.
- seg  out  7  active-high segments, seg[6]=A … seg[0]=G.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable; bit 0 is the leftmost/first letter.
- day  out  3  current day index.
- day_tick  out  1  one-cycle pulse coincident with every day change.

## Operation
- State: day (3b), dwell_cnt (clog2(DWELL) bits, min 1), scan_cnt (clog2(SCAN_DIV) bits, min 1), scan_idx (0..NUM_DIGITS-1).
- All outputs are registers, updated on the same edge as the state they reflect. No combinational path from inputs to outputs.
- Reset (rst_n=0 at edge): day=0, dwell_cnt=0, scan_cnt=0, scan_idx=0, digit_sel=1, seg=letter M, day_tick=0. Reset overrides load and en.
- Dwell: when en=1, dwell_cnt increments. When en=1 and dwell_cnt==DWELL-1, the day advances:
  - dwell_cnt returns to 0.
  - day becomes (day+1) mod 7 if dir=0, (day+6) mod 7 if dir=1, so SUN→MON forward and MON→SUN backward.
  - day_tick=1 for that cycle.
- When en=0, dwell_cnt holds, day holds and day_tick=0.
- Load has priority over advance. On load=1: day=load_day (7→0), dwell_cnt=0, day_tick=0 even if the terminal count coincides. The load acts regardless of en.
- dir is sampled only at an advance. Changing it mid-dwell does not reset dwell_cnt.
- Scan:
  - scan_cnt counts every cycle. At SCAN_DIV-1 it wraps to 0 and scan_idx advances, wrapping NUM_DIGITS-1→0.
  - digit_sel = 1<<scan_idx.
  - seg = glyph(name[day][scan_idx]).
  - With NUM_DIGITS=1, scan_idx stays 0 and digit_sel stays 1.
- Names: MON TUE WED THU FRI SAT SUN.
- Glyphs, bits ABCDEFG:
  - A 1110111, D 0111101, E 1001111, F 1000111, H 0110111, I 0110000, M 1110110.
  - N 0010101, O 1111110, R 0000101, S 1011011, T 0001111, U 0111110, W 0111111.
  - Any other code gives 0000000.
- A day change updates seg on the same edge for the currently selected digit. It does not restart scanning.

## Timing
- After rst_n is released with en=1 held, the first day_tick comes on the DWELL-th rising edge after release, then every DWELL edges.
- Each digit is selected for exactly SCAN_DIV cycles. Full frame = NUM_DIGITS×SCAN_DIV cycles.
- Load: day, seg and dwell restart are visible the edge after load is sampled. The next advance follows DWELL enabled cycles later.
- DWELL=1 with en=1 advances every cycle and holds day_tick high continuously.
- When rst_n is asserted mid-dwell or mid-scan, all state takes reset values at the next edge. No partial day_tick.

## Test plan
Parameters for all scenarios: DWELL=4, SCAN_DIV=2, NUM_DIGITS=3.
- Reset, then en=1 for 28 cycles:
  - day = 0,1,…,6,0, changing every 4 cycles.
  - day_tick pulses at cycles 4, 8, … 28.
  - seq wraps SUN→MON.
- Scanning at day=0:
  - digit_sel = 001,001,010,010,100,100,001…
  - seg = 1110110, 1111110, 0010101 (M O N).
- dir=1 from day=0, en=1: day goes to 6 after 4 cycles, then 5, and seg shows S U N.
- en toggles 1,1,0,0,0,1,1 from reset: the first tick occurs on the 4th enabled cycle, which is clock 7. Scanning continues through the hold.
- load=1, load_day=4 on the same cycle as the terminal count: day=4, no tick, next tick 4 enabled cycles later. Repeat with load_day=7: day=0.
- Assert rst_n=0 mid-dwell at day=3: the next edge gives day=0, digit_sel=001, seg=1110110, day_tick=0.
